// File: rtl/mul_iter_if.sv
// Register-file side bundle for the iterative multiplier: operand/request
// signals from the read ports and the single-cycle write-back to the write port.
interface mul_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] rn_val;
  logic [WIDTH-1:0] rm_val;
  logic [WIDTH-1:0] ra_val;
  logic             acc_en;
  logic [3:0]       rd_addr;
  logic             set_flags;
  logic             busy;
  logic             wb_we;
  logic [3:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             flags_we;
  logic             flag_n;
  logic             flag_z;

  // Requester side (control path / register file)
  modport master (
    output start, rn_val, rm_val, ra_val, acc_en, rd_addr, set_flags,
    input  busy, wb_we, wb_addr, wb_data, flags_we, flag_n, flag_z
  );

  // Multiplier side
  modport slave (
    input  start, rn_val, rm_val, ra_val, acc_en, rd_addr, set_flags,
    output busy, wb_we, wb_addr, wb_data, flags_we, flag_n, flag_z
  );
endinterface

// File: rtl/mul_iter_unit.sv
// mul_iter_unit: iterative radix-2 shift-add multiplier (low WIDTH bits of
// rn*rm) with a one-cycle register-file write-back and N/Z flag strobe.
// Optional multiply-accumulate (product preloaded with ra) when the macro
// MUL_MLA_EN is defined; default build is plain MUL.
module mul_iter_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  mul_iter_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mlier;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] prod_next;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       rd_q;
  logic             sf_q;

`ifndef MUL_MLA_EN
  // Accumulate inputs have no function in the plain-MUL build.
  logic unused_mla;
  assign unused_mla = ^{bus.ra_val, bus.acc_en};
`endif

  // Partial product after the current iteration (wraps modulo 2^WIDTH)
  always_comb begin
    prod_next = prod + (mlier[0] ? mcand : '0);
  end

  assign bus.busy = (state != IDLE);

  // Control FSM, shift-add datapath and registered write-back outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mcand        <= '0;
      mlier        <= '0;
      prod         <= '0;
      cnt          <= '0;
      rd_q         <= '0;
      sf_q         <= 1'b0;
      bus.wb_we    <= 1'b0;
      bus.wb_addr  <= '0;
      bus.wb_data  <= '0;
      bus.flags_we <= 1'b0;
      bus.flag_n   <= 1'b0;
      bus.flag_z   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.wb_we    <= 1'b0;
          bus.flags_we <= 1'b0;
          if (bus.start) begin
            mcand <= bus.rn_val;
            mlier <= bus.rm_val;
            rd_q  <= bus.rd_addr;
            sf_q  <= bus.set_flags;
`ifdef MUL_MLA_EN
            prod  <= bus.acc_en ? bus.ra_val : '0;
`else
            prod  <= '0;
`endif
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          prod  <= prod_next;
          mcand <= mcand << 1;
          mlier <= mlier >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) begin
            // Outputs are loaded from the final partial product so they are
            // registered yet visible in the very cycle the FSM sits in WB.
            state        <= WB;
            bus.wb_data  <= prod_next;
            bus.wb_addr  <= rd_q;
            bus.wb_we    <= (rd_q != 4'hF);
            bus.flags_we <= sf_q;
            bus.flag_n   <= prod_next[WIDTH-1];
            bus.flag_z   <= (prod_next == '0);
          end
        end
        WB: begin
          bus.wb_we    <= 1'b0;
          bus.flags_we <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          bus.wb_we    <= 1'b0;
          bus.flags_we <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
